// File: rtl/rram_ctrl_pkg.sv
// Shared types and constants for the RRAM write-verify controller.
package rram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_VCMD = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/rram_write_verify_ctrl.sv
// Host-side initiator for a single-port RRAM macro: reads, and writes with
// read-back verify and bounded re-programming on mismatch.
module rram_write_verify_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int MAX_RETRIES = 3,
    parameter int RETRY_W     = 2
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [RETRY_W-1:0]    resp_retries,
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0
);

    state_t                state_r;
    state_t                next_state_s;
    logic                  accept_s;
    logic                  match_s;
    logic                  at_limit_s;
    logic                  we_r;
    logic                  we_nx_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [RETRY_W-1:0]    retries_r;
    logic                  csb0_s;
    logic                  web0_s;
    logic                  ready_s;
    logic                  resp_valid_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign match_s    = (mem_dout0 == wdata_r);
    assign at_limit_s = (retries_r >= RETRY_W'(MAX_RETRIES));
    assign we_nx_s    = accept_s ? req_we : we_r;

    // The macro pins mirror the latched request, so they stay still while csb0 is high.
    assign mem_addr0 = addr_r;
    assign mem_din0  = wdata_r;

    // State register.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic, including the verify/retry decision at the end of WAIT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = ST_CMD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (we_r == REQ_WRITE) begin
                    next_state_s = ST_VCMD;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_VCMD: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (we_r == REQ_READ) begin
                    next_state_s = ST_RESP;
                end else if (match_s || at_limit_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_CMD;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the strobes are registered yet aligned with the state.
    always_comb begin
        csb0_s       = 1'b1;
        web0_s       = 1'b1;
        ready_s      = 1'b0;
        resp_valid_s = 1'b0;
        case (next_state_s)
            ST_IDLE: ready_s = 1'b1;
            ST_CMD: begin
                csb0_s = 1'b0;
                web0_s = ~we_nx_s;
            end
            ST_VCMD: csb0_s = 1'b0;
            ST_WAIT: csb0_s = 1'b1;
            ST_RESP: resp_valid_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            mem_csb0   <= 1'b1;
            mem_web0   <= 1'b1;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            mem_csb0   <= csb0_s;
            mem_web0   <= web0_s;
            req_ready  <= ready_s;
            resp_valid <= resp_valid_s;
        end
    end

    // Request latch, retry counter and response capture.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            we_r         <= REQ_READ;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            retries_r    <= {RETRY_W{1'b0}};
            resp_rdata   <= {DATA_WIDTH{1'b0}};
            resp_err     <= 1'b0;
            resp_retries <= {RETRY_W{1'b0}};
        end else begin
            if (accept_s) begin
                we_r      <= req_we;
                addr_r    <= req_addr;
                wdata_r   <= req_wdata;
                retries_r <= {RETRY_W{1'b0}};
            end
            if (state_r == ST_WAIT && next_state_s == ST_CMD) begin
                retries_r <= retries_r + RETRY_W'(1);
            end
            // Response fields change only when a new response is issued.
            if (state_r == ST_WAIT && next_state_s == ST_RESP) begin
                resp_rdata   <= mem_dout0;
                resp_err     <= (we_r == REQ_WRITE) && !match_s;
                resp_retries <= retries_r;
            end
        end
    end

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Directed bench for rram_write_verify_ctrl with a 64x64 macro model and a
// programming-fault hook (bit0 stuck at 0 for the first N programs of one address).
module tb_rram_write_verify_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = 6'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_retries;
    logic        mem_csb0;
    logic        mem_web0;
    logic [5:0]  mem_addr0;
    logic [63:0] mem_din0;
    logic [63:0] mem_dout0;

    int checks = 0;
    int errors = 0;

    rram_write_verify_ctrl dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_retries(resp_retries),
        .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
        .mem_din0(mem_din0), .mem_dout0(mem_dout0)
    );

    always #5 clk0 = ~clk0;

    // Macro model state and hooks
    logic [63:0] mem [64];
    logic        cap_csb, cap_web;
    logic [5:0]  cap_addr;
    logic [63:0] cap_din;
    int          wr_pulses, rd_pulses, fault_hits;
    logic        hook_clr = 1'b0;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = 6'd0;
    logic [63:0] pl_data = 64'd0;
    logic [5:0]  fault_addr = 6'd0;
    int          fault_n = 0;

    always @(posedge clk0) begin
        cap_csb  <= mem_csb0;
        cap_web  <= mem_web0;
        cap_addr <= mem_addr0;
        cap_din  <= mem_din0;
        if (hook_clr) begin
            wr_pulses <= 0;
            rd_pulses <= 0;
        end else if (mem_csb0 === 1'b0) begin
            if (mem_web0 === 1'b0) wr_pulses <= wr_pulses + 1;
            else                   rd_pulses <= rd_pulses + 1;
        end
    end

    always @(negedge clk0) begin
        if (hook_clr) fault_hits <= 0;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (cap_csb === 1'b0) begin
            if (cap_web === 1'b0) begin
                if (cap_addr == fault_addr && fault_hits < fault_n) begin
                    mem[cap_addr] <= cap_din & ~64'h1;
                    fault_hits    <= fault_hits + 1;
                end else begin
                    mem[cap_addr] <= cap_din;
                end
            end else begin
                mem_dout0 <= mem[cap_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [63:0] d);
        @(posedge clk0); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk0); #1;
        pl_en = 1'b0;
    endtask

    task automatic arm(input logic [5:0] a, input int n);
        fault_addr = a; fault_n = n;
        @(posedge clk0); #1;
        hook_clr = 1'b1;
        @(posedge clk0); #1;
        hook_clr = 1'b0;
    endtask

    // Issue one request and wait (bounded) for its response; lat = -1 on timeout.
    task automatic run_req(input logic we, input logic [5:0] a, input logic [63:0] d,
                           output int lat, output logic [63:0] rd, output logic err,
                           output logic [1:0] ret);
        int w;
        lat = -1; rd = 64'd0; err = 1'b0; ret = 2'd0;
        w = 0;
        @(negedge clk0);
        while (!req_ready && w < 20) begin
            @(negedge clk0);
            w++;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk0); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk0); #1;
            if (resp_valid) begin
                lat = i; rd = resp_rdata; err = resp_err; ret = resp_retries;
                break;
            end
        end
        @(posedge clk0); #1;
        chk("resp_valid_one_cycle", {63'd0, resp_valid}, 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
        int          fault_n;
        int          exp_lat;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_ret;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          lat;
        logic [63:0] rd;
        logic        err;
        logic [1:0]  ret;
        logic [5:0]  b2b_addr [3];
        logic [63:0] b2b_exp [3];
        int          acc_cyc [3];
        int          nacc, nresp;
        logic        acc;
        bit          seen_resp;

        vecs[0] = '{1'b0, 6'd5,  64'd0,                  0,   2,  64'hDEAD_BEEF_0123_4567, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 6'd9,  64'hA5A5_A5A5_A5A5_A5A5, 0,   3,  64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 6'd12, 64'h1,                  1,   6,  64'h1,                  1'b0, 2'd1};
        vecs[3] = '{1'b1, 6'd20, 64'h0123_4567_89AB_CDEF, 100, 12, 64'h0123_4567_89AB_CDEE, 1'b1, 2'd3};
        vecs[4] = '{1'b1, 6'd30, 64'hFFFF_0000_FFFF_0001, 2,   9,  64'hFFFF_0000_FFFF_0001, 1'b0, 2'd2};
        vecs[5] = '{1'b0, 6'd9,  64'd0,                  0,   2,  64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 2'd0};
        vecs[6] = '{1'b0, 6'd20, 64'd0,                  0,   2,  64'h0123_4567_89AB_CDEE, 1'b0, 2'd0};
        vecs[7] = '{1'b1, 6'd33, 64'h0,                  100, 3,  64'h0,                  1'b0, 2'd0};

        // Reset values
        #12;
        chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_err",   {63'd0, resp_err},   64'd0);
        chk("rst_resp_ret",   {62'd0, resp_retries}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_csb0",       {63'd0, mem_csb0},   64'd1);
        chk("rst_web0",       {63'd0, mem_web0},   64'd1);
        chk("rst_addr0",      {58'd0, mem_addr0},  64'd0);
        chk("rst_din0",       mem_din0, 64'd0);
        @(negedge clk0);
        rst0 = 1'b0;

        preload(6'd5, 64'hDEAD_BEEF_0123_4567);

        for (int v = 0; v < 8; v++) begin
            arm(vecs[v].addr, vecs[v].fault_n);
            run_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd, err, ret);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("v%0d_err", v), {63'd0, err}, {63'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_retries", v), {62'd0, ret}, {62'd0, vecs[v].exp_ret});
            if (vecs[v].we) begin
                chk($sformatf("v%0d_wr_pulses", v), 64'(wr_pulses), 64'(int'(vecs[v].exp_ret) + 1));
                chk($sformatf("v%0d_rd_pulses", v), 64'(rd_pulses), 64'(int'(vecs[v].exp_ret) + 1));
                chk($sformatf("v%0d_mem", v), mem[vecs[v].addr], vecs[v].exp_rdata);
            end else begin
                chk($sformatf("v%0d_wr_pulses", v), 64'(wr_pulses), 64'd0);
                chk($sformatf("v%0d_rd_pulses", v), 64'(rd_pulses), 64'd1);
            end
        end

        // Reset during VCMD: strobes drop at once, no response follows
        @(negedge clk0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd40; req_wdata = 64'h1234;
        @(posedge clk0); #1;
        req_valid = 1'b0;
        @(posedge clk0); #1;
        chk("vcmd_csb0_low", {63'd0, mem_csb0}, 64'd0);
        chk("vcmd_web0_high", {63'd0, mem_web0}, 64'd1);
        #2 rst0 = 1'b1;
        #1;
        chk("midrst_csb0", {63'd0, mem_csb0}, 64'd1);
        chk("midrst_web0", {63'd0, mem_web0}, 64'd1);
        seen_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk0); #1;
            if (resp_valid) seen_resp = 1'b1;
        end
        @(negedge clk0);
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk0); #1;
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("midrst_no_resp", {63'd0, seen_resp}, 64'd0);
        run_req(1'b0, 6'd5, 64'd0, lat, rd, err, ret);
        chk("postrst_latency", 64'(lat), 64'd2);
        chk("postrst_rdata", rd, 64'hDEAD_BEEF_0123_4567);

        // Back-to-back reads with valid held high
        b2b_addr[0] = 6'd5;  b2b_exp[0] = 64'hDEAD_BEEF_0123_4567;
        b2b_addr[1] = 6'd9;  b2b_exp[1] = 64'hA5A5_A5A5_A5A5_A5A5;
        b2b_addr[2] = 6'd12; b2b_exp[2] = 64'h1;
        nacc = 0; nresp = 0;
        @(negedge clk0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = b2b_addr[0];
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk0);
            acc = req_valid && req_ready;
            @(posedge clk0); #1;
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                chk("b2b_ready_low", {63'd0, req_ready}, 64'd0);
                if (nacc < 3) req_addr = b2b_addr[nacc];
                else          req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (nresp < 3) chk($sformatf("b2b_rdata%0d", nresp), resp_rdata, b2b_exp[nresp]);
                nresp++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_nresp", 64'(nresp), 64'd3);
        chk("b2b_nacc", 64'(nacc), 64'd3);
        if (nacc == 3) begin
            chk("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
            chk("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
